// File: rtl/tmds_channel_rx.sv
// TMDS colour-channel receiver: bit-serial in, word alignment from control tokens,
// then 10b->8b data decode or {C1,C0} control recovery, one strobe per symbol.
module tmds_channel_rx #(
    parameter int LOCK_TOKENS  = 8,
    parameter int UNLOCK_WORDS = 2048
) (
    input  logic       i_tmdsclk,
    input  logic       i_reset_n,
    input  logic       i_serial,
    output logic       o_locked,
    output logic       o_valid,
    output logic       o_de,
    output logic [7:0] o_data,
    output logic [1:0] o_ctrl
);

    localparam int HIT_W = $clog2(LOCK_TOKENS + 1);
    localparam int TO_W  = $clog2(UNLOCK_WORDS + 1);
    localparam logic [HIT_W-1:0] HIT_LOCK = HIT_W'(LOCK_TOKENS);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(UNLOCK_WORDS);

    typedef enum logic {S_SEARCH, S_LOCKED} state_t;

    state_t           r_state;
    logic [9:0]       r_sr_p0;
    logic [3:0]       r_bitcnt;
    logic [HIT_W-1:0] r_hit_cnt;
    logic [TO_W-1:0]  r_timeout;

    logic [2:0]       w_tok;
    logic             w_is_tok;
    logic [1:0]       w_tok_c;
    logic             w_boundary;
    logic [HIT_W-1:0] w_hit_inc;
    logic [TO_W-1:0]  w_to_inc;

    // Returns {is_token, C1, C0}
    function automatic logic [2:0] token_match(input logic [9:0] sym);
        case (sym)
            10'b1101010100: token_match = 3'b100;
            10'b0010101011: token_match = 3'b101;
            10'b0101010100: token_match = 3'b110;
            10'b1010101011: token_match = 3'b111;
            default:        token_match = 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] sym);
        logic [7:0] q;
        logic [7:0] d;
        q    = sym[9] ? ~sym[7:0] : sym[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

    assign w_tok      = token_match(r_sr_p0);
    assign w_is_tok   = w_tok[2];
    assign w_tok_c    = w_tok[1:0];
    assign w_boundary = (r_bitcnt == 4'd0);
    assign w_hit_inc  = r_hit_cnt + 1'b1;
    assign w_to_inc   = r_timeout + 1'b1;

    always_ff @(posedge i_tmdsclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_SEARCH;
            r_sr_p0   <= '0;
            r_bitcnt  <= '0;
            r_hit_cnt <= '0;
            r_timeout <= '0;
            o_locked  <= 1'b0;
            o_valid   <= 1'b0;
            o_de      <= 1'b0;
            o_data    <= '0;
            o_ctrl    <= '0;
        end else begin
            r_sr_p0  <= {i_serial, r_sr_p0[9:1]};
            r_bitcnt <= (r_bitcnt == 4'd9) ? 4'd0 : r_bitcnt + 4'd1;
            o_valid  <= 1'b0;
            case (r_state)
                S_SEARCH: begin
                    if (w_is_tok) begin
                        if (w_boundary && (r_hit_cnt != '0)) begin
                            r_hit_cnt <= w_hit_inc;
                            if (w_hit_inc == HIT_LOCK) begin
                                r_state   <= S_LOCKED;
                                o_locked  <= 1'b1;
                                r_timeout <= '0;
                            end
                        end else begin
                            // First sighting or wrong phase: restart the count and
                            // treat this cycle as the symbol boundary.
                            r_hit_cnt <= HIT_W'(1);
                            r_bitcnt  <= 4'd1;
                        end
                    end else if (w_boundary && (r_hit_cnt != '0)) begin
                        r_hit_cnt <= '0;
                    end
                end
                S_LOCKED: begin
                    if (w_boundary) begin
                        if (w_is_tok) begin
                            o_valid   <= 1'b1;
                            o_de      <= 1'b0;
                            o_ctrl    <= w_tok_c;
                            r_timeout <= '0;
                        end else if (w_to_inc == TO_LIMIT) begin
                            // Too long without a token: alignment is suspect, drop this word.
                            r_state   <= S_SEARCH;
                            o_locked  <= 1'b0;
                            r_hit_cnt <= '0;
                        end else begin
                            o_valid   <= 1'b1;
                            o_de      <= 1'b1;
                            o_data    <= tmds_decode(r_sr_p0);
                            r_timeout <= w_to_inc;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmds_channel_rx.sv
// Bench for tmds_channel_rx: serial symbol stimulus, a table of hand-decoded symbols,
// lock/unlock/reset sequences and an encoder-driven stream, checked by a scoreboard.
module tb_tmds_channel_rx;

    localparam int UNLOCK = 2048;
    localparam logic [9:0] TOK00 = 10'h354;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser = 1'b0;
    logic       locked;
    logic       valid;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;

    tmds_channel_rx #(.LOCK_TOKENS(8), .UNLOCK_WORDS(UNLOCK)) dut (
        .i_tmdsclk(clk),
        .i_reset_n(rst_n),
        .i_serial (ser),
        .o_locked (locked),
        .o_valid  (valid),
        .o_de     (de),
        .o_data   (data),
        .o_ctrl   (ctrl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       de;
        logic [7:0] data;
        logic [1:0] ctrl;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [9:0] sym;
        logic       de;
        logic [7:0] data;
        logic [1:0] ctrl;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_done = 0;
    int   disp = 0;
    logic exp_locked = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every expected word must appear exactly one clock after it completed.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL missing_valid: o_valid=0 at cycle %0d, required 1", sb[0].cyc);
                void'(sb.pop_front());
            end
            if (valid) begin
                tests++;
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    e = sb.pop_front();
                    if (de !== e.de || data !== e.data || ctrl !== e.ctrl) begin
                        fails++;
                        $display("FAIL word_out cyc %0d: got de=%b data=%h ctrl=%b, required de=%b data=%h ctrl=%b",
                                 cyc, de, data, ctrl, e.de, e.data, e.ctrl);
                    end
                end else begin
                    fails++;
                    $display("FAIL spurious_valid: o_valid=1 at cycle %0d, required 0", cyc);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic send_bit(input logic b);
        ser = b;
        @(posedge clk);
        #1;
    endtask

    // o_locked is checked one clock after the previous word completed.
    task automatic send_word(input logic [9:0] sym);
        for (int i = 0; i < 10; i++) begin
            send_bit(sym[i]);
            if (i == 0) chk("lock_state", {7'd0, locked}, {7'd0, exp_locked});
        end
        last_done = cyc;
    endtask

    task automatic expect_out(input logic e_de, input logic [7:0] e_data, input logic [1:0] e_ctrl);
        exp_t e;
        e.de   = e_de;
        e.data = e_data;
        e.ctrl = e_ctrl;
        e.cyc  = last_done + 1;
        sb.push_back(e);
    endtask

    task automatic lock8();
        repeat (8) send_word(TOK00);
        exp_locked = 1'b1;
    endtask

    function automatic logic [9:0] tok(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    // Transmitter-side TMDS encoder with running disparity.
    task automatic enc(input logic [7:0] d, output logic [9:0] sym);
        logic [8:0] qm;
        int n1, n1q, n0q;
        n1    = $countones(d);
        qm[0] = d[0];
        if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (disp == 0 || n1q == n0q) begin
            sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            if (qm[8] == 1'b0) disp += n0q - n1q;
            else               disp += n1q - n0q;
        end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
            sym  = {1'b1, qm[8], ~qm[7:0]};
            disp += (qm[8] ? 2 : 0) + n0q - n1q;
        end else begin
            sym  = {1'b0, qm[8], qm[7:0]};
            disp += -(qm[8] ? 0 : 2) + n1q - n0q;
        end
    endtask

    initial begin
        logic [9:0] sym;
        logic [7:0] b;
        logic [7:0] last_data;
        logic [1:0] c;
        logic [1:0] cur_ctrl;

        vecs[0]  = '{10'h100, 1'b1, 8'h00, 2'b00};
        vecs[1]  = '{10'h2FF, 1'b1, 8'hFE, 2'b00};
        vecs[2]  = '{10'h2AB, 1'b0, 8'hFE, 2'b11};
        vecs[3]  = '{10'h1FF, 1'b1, 8'h01, 2'b11};
        vecs[4]  = '{10'h0AB, 1'b0, 8'h01, 2'b01};
        vecs[5]  = '{10'h0FF, 1'b1, 8'hFF, 2'b01};
        vecs[6]  = '{10'h155, 1'b1, 8'hFF, 2'b01};
        vecs[7]  = '{10'h154, 1'b0, 8'hFF, 2'b10};
        vecs[8]  = '{10'h300, 1'b1, 8'h01, 2'b10};
        vecs[9]  = '{10'h2AA, 1'b1, 8'h01, 2'b10};
        vecs[10] = '{10'h354, 1'b0, 8'h01, 2'b00};
        vecs[11] = '{10'h2AB, 1'b0, 8'h01, 2'b11};

        // Reset state, then junk bits and eight tokens to lock
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", {7'd0, locked}, 8'd0);
        chk("rst_valid",  {7'd0, valid},  8'd0);
        chk("rst_de",     {7'd0, de},     8'd0);
        chk("rst_data",   data,           8'h00);
        chk("rst_ctrl",   {6'd0, ctrl},   8'd0);
        rst_n = 1'b1;
        repeat (3) send_bit(1'b1);
        lock8();

        // Table of hand-decoded symbols while locked
        for (int i = 0; i < 12; i++) begin
            send_word(vecs[i].sym);
            expect_out(vecs[i].de, vecs[i].data, vecs[i].ctrl);
        end

        // Token starvation: the 2048th data word unlocks and produces no strobe
        for (int k = 0; k < UNLOCK; k++) begin
            send_word(10'h2FF);
            if (k < UNLOCK - 1) expect_out(1'b1, 8'hFE, 2'b11);
        end
        exp_locked = 1'b0;
        lock8();
        send_word(10'h2FF);
        expect_out(1'b1, 8'hFE, 2'b11);

        // Asynchronous reset in the middle of a symbol
        repeat (4) send_bit(1'b1);
        chk("pre_rst_data", data, 8'hFE);
        rst_n = 1'b0;
        #1;
        chk("arst_locked", {7'd0, locked}, 8'd0);
        chk("arst_valid",  {7'd0, valid},  8'd0);
        chk("arst_de",     {7'd0, de},     8'd0);
        chk("arst_data",   data,           8'h00);
        chk("arst_ctrl",   {6'd0, ctrl},   8'd0);
        sb.delete();
        exp_locked = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Five aligned tokens, a one-bit slip, then eight tokens from the new phase
        repeat (5) send_word(TOK00);
        send_bit(1'b0);
        lock8();

        // Encoded random pixels with blanking carrying hsync/vsync
        last_data = 8'h00;
        cur_ctrl  = 2'b00;
        for (int line = 0; line < 3; line++) begin
            for (int t = 0; t < 160; t++) begin
                c = {(line == 0 && t < 80), (t >= 16 && t < 64)};
                send_word(tok(c));
                expect_out(1'b0, last_data, c);
                cur_ctrl = c;
                disp = 0;
            end
            for (int p = 0; p < 64; p++) begin
                b = 8'($urandom_range(0, 255));
                enc(b, sym);
                send_word(sym);
                expect_out(1'b1, b, cur_ctrl);
                last_data = b;
            end
        end

        send_bit(1'b0);
        send_bit(1'b0);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d words outstanding, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
